tour_cmd: RTL and testbench
===========================

TOUR_CMD -- requirements
Module: tour_cmd

Interface
REQ-001 SHALL have the following ports (name  direction  width  meaning):
- clk  in  1  system clock (50MHz); single clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- tour_go  in  1  one-clk pulse from cmd_proc that starts the tour replay.
- move  in  8  one-hot knight move for the current index, from tour logic.
- mv_indx  out  5  index of the move being replayed, 0..23.
- cmd_UART  in  16  command assembled by UART_wrapper.
- cmd_rdy_UART  in  1  UART command valid.
- clr_cmd_rdy_UART  out  1  consume strobe to UART_wrapper.
- cmd  out  16  command to cmd_proc.
- cmd_rdy  out  1  command valid to cmd_proc.
- clr_cmd_rdy  in  1  cmd_proc consumed cmd.
- send_resp  in  1  cmd_proc finished the current command.
- resp  out  8  response byte to UART_wrapper.

Function
REQ-002 SHALL implement FSM states IDLE, L1_CMD, L1_WAIT, L2_CMD, L2_WAIT.
REQ-003 In IDLE: cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy (pass-through); resp=8'hA5.
REQ-004 tour_go in IDLE: mv_indx<=0, next state L1_CMD; tour_go outside IDLE SHALL be ignored.
REQ-005 Outside IDLE: cmd_rdy_UART ignored, clr_cmd_rdy_UART=0, cmd and cmd_rdy driven internally.
REQ-006 Command format: [15:12] opcode (4'h2 move, 4'h3 move+fanfare), [11:4] heading (N=8'h00, W=8'h3F, S=8'h7F, E=8'hBF), [3:0] squares.
REQ-007 Decode of move (leg1 = 2 squares, opcode 2; leg2 = 1 square, opcode 3): bit0 N/W, bit1 N/E, bit2 W/N, bit3 W/S, bit4 S/W, bit5 S/E, bit6 E/N, bit7 E/S.
REQ-008 Multiple bits set: lowest set bit SHALL be used; move==8'h00 in L1_CMD SHALL end the tour (to IDLE, no command issued).
REQ-009 L1_CMD/L2_CMD: cmd_rdy=1, cmd=leg command; held stable until clr_cmd_rdy, then to L1_WAIT/L2_WAIT.
REQ-010 L1_WAIT: on send_resp -> L2_CMD. L2_WAIT: on send_resp, mv_indx==23 -> IDLE; else mv_indx+1 -> L1_CMD.
REQ-011 Latency: cmd_rdy SHALL assert the clk after tour_go, and the clk after the send_resp that enters L2_CMD or L1_CMD.
REQ-012 resp SHALL be 8'h5A outside IDLE, except 8'hA5 in L2_WAIT when mv_indx==23 (final response).
REQ-013 clr_cmd_rdy and send_resp asserted in the same cycle SHALL be handled in order: consume first, send_resp ignored that cycle.
REQ-014 mv_indx SHALL NOT wrap; maximum value 23.

Reset
REQ-015 On rst_n=0 at clk rise: state IDLE, mv_indx=0; outputs follow IDLE pass-through (cmd_rdy=cmd_rdy_UART, resp=8'hA5).
REQ-016 Reset mid-tour SHALL abandon the tour with no further commands issued.

Configuration
REQ-017 Macro TOUR_ABORT_EN: when defined, cmd_rdy_UART with cmd_UART[15:12]==4'hF outside IDLE SHALL latch an abort flag and pulse clr_cmd_rdy_UART for one clk.
REQ-018 With the abort flag set, the next send_resp in L1_WAIT or L2_WAIT SHALL go to IDLE with mv_indx=0 and resp=8'hA5; the flag clears in IDLE.
REQ-019 When TOUR_ABORT_EN is undefined, all UART commands outside IDLE SHALL be ignored (REQ-005).

Verification
REQ-020 Idle pass-through: cmd_UART=16'h2001, cmd_rdy_UART=1 -> cmd=16'h2001, cmd_rdy=1 in the same cycle; clr_cmd_rdy=1 -> clr_cmd_rdy_UART=1.
REQ-021 tour_go with move=8'h01 -> next clk cmd=16'h2002, cmd_rdy=1; after clr_cmd_rdy and send_resp -> cmd=16'h33F1.
REQ-022 move=8'h80 at mv_indx=5 -> legs 16'h2BF2 then 16'h37F1; after second send_resp mv_indx=6, resp=8'h5A.
REQ-023 Full 24-move run -> 48 commands issued, final resp=8'hA5, state IDLE, mv_indx=23 held; then tour_go restarts at mv_indx=0.
REQ-024 move=8'h00 at mv_indx=3 -> no cmd_rdy, return to IDLE; rst_n low mid-L2_WAIT -> IDLE, mv_indx=0.
REQ-025 TOUR_ABORT_EN defined: cmd_UART=16'hF000 mid-L1_WAIT -> one clr_cmd_rdy_UART pulse; next send_resp -> IDLE, resp=8'hA5. Undefined: no pulse, tour continues.

Source files
------------

// File: rtl/tour_cmd_if.sv
//------------------------------------------------------------------
// tour_cmd_if : command/response bundle between tour logic and tour_cmd
// Rev 1.0
//------------------------------------------------------------------
`default_nettype none

interface tour_cmd_if;
  logic        tour_go;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;

  modport master (
    output tour_go, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    input  mv_indx, clr_cmd_rdy_UART, cmd, cmd_rdy, resp
  );

  modport slave (
    input  tour_go, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    output mv_indx, clr_cmd_rdy_UART, cmd, cmd_rdy, resp
  );
endinterface

`default_nettype wire

// File: rtl/tour_cmd.sv
//------------------------------------------------------------------
// tour_cmd : UART command pass-through / knight-tour replay muxer
// Optional abort feature: define TOUR_ABORT_EN.        Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module tour_cmd (
  input  logic       clk,
  input  logic       rst_n,
  tour_cmd_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    L1_CMD  = 3'd1,
    L1_WAIT = 3'd2,
    L2_CMD  = 3'd3,
    L2_WAIT = 3'd4
  } state_t;

  localparam logic [4:0] LAST_INDX = 5'd23;

  state_t      state, state_nxt;
  logic [4:0]  mv_indx, mv_indx_nxt;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_uart;
  logic [7:0]  resp;
  logic [2:0]  bit_sel;
  logic [1:0]  dir1, dir2;
  logic [15:0] leg1, leg2;
  logic        send_ok;
  logic        abort;
  logic        abort_req;

  function automatic logic [7:0] heading(input logic [1:0] dir);
    case (dir)
      2'd0:    heading = 8'h00;
      2'd1:    heading = 8'h3F;
      2'd2:    heading = 8'h7F;
      default: heading = 8'hBF;
    endcase
  endfunction

  // Lowest set bit wins; dirs are 0=N 1=W 2=S 3=E.
  always_comb begin
    bit_sel = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (bus.move[i]) bit_sel = 3'(i);
    end
  end

  assign dir1 = bit_sel[2:1];
  assign dir2 = {bit_sel[0], ~dir1[0]};
  assign leg1 = {4'h2, heading(dir1), 4'h2};
  assign leg2 = {4'h3, heading(dir2), 4'h1};

  // A consume in the same cycle takes priority over send_resp.
  assign send_ok = bus.send_resp & ~bus.clr_cmd_rdy;

`ifdef TOUR_ABORT_EN
  assign abort_req = (state != IDLE) && bus.cmd_rdy_UART &&
                     (bus.cmd_UART[15:12] == 4'hF) && !abort;

  always_ff @(posedge clk) begin
    if (!rst_n)             abort <= 1'b0;
    else if (state == IDLE) abort <= 1'b0;
    else if (abort_req)     abort <= 1'b1;
  end
`else
  assign abort_req = 1'b0;
  assign abort     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      mv_indx <= 5'd0;
    end else begin
      state   <= state_nxt;
      mv_indx <= mv_indx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    mv_indx_nxt = mv_indx;
    cmd         = bus.cmd_UART;
    cmd_rdy     = 1'b0;
    clr_uart    = 1'b0;
    resp        = 8'h5A;
    case (state)
      IDLE: begin
        cmd_rdy  = bus.cmd_rdy_UART;
        clr_uart = bus.clr_cmd_rdy;
        resp     = 8'hA5;
        if (bus.tour_go) begin
          mv_indx_nxt = 5'd0;
          state_nxt   = L1_CMD;
        end
      end
      L1_CMD: begin
        cmd = leg1;
        if (bus.move == 8'h00) begin
          state_nxt = IDLE;
        end else begin
          cmd_rdy = 1'b1;
          if (bus.clr_cmd_rdy) state_nxt = L1_WAIT;
        end
      end
      L1_WAIT: begin
        cmd = leg1;
        if (send_ok) begin
          if (abort) begin
            state_nxt   = IDLE;
            mv_indx_nxt = 5'd0;
          end else begin
            state_nxt = L2_CMD;
          end
        end
      end
      L2_CMD: begin
        cmd     = leg2;
        cmd_rdy = 1'b1;
        if (bus.clr_cmd_rdy) state_nxt = L2_WAIT;
      end
      L2_WAIT: begin
        cmd = leg2;
        if (mv_indx == LAST_INDX) resp = 8'hA5;
        if (send_ok) begin
          if (abort) begin
            state_nxt   = IDLE;
            mv_indx_nxt = 5'd0;
          end else if (mv_indx == LAST_INDX) begin
            state_nxt = IDLE;
          end else begin
            mv_indx_nxt = mv_indx + 5'd1;
            state_nxt   = L1_CMD;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (abort_req) clr_uart = 1'b1;
  end

  assign bus.cmd              = cmd;
  assign bus.cmd_rdy          = cmd_rdy;
  assign bus.clr_cmd_rdy_UART = clr_uart;
  assign bus.resp             = resp;
  assign bus.mv_indx          = mv_indx;

endmodule

`default_nettype wire

// File: tb/tb_tour_cmd.sv
//------------------------------------------------------------------
// tb_tour_cmd : self-checking bench for tour_cmd
// Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module tb_tour_cmd;

  logic clk = 1'b0;
  logic rst_n;
  always #10 clk = ~clk;

  tour_cmd_if bus ();
  tour_cmd dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [7:0] mv_tab [24];
  assign bus.move = mv_tab[bus.mv_indx];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: each move is a pair of compass directions, picked by lowest set bit.
  function automatic logic [15:0] leg_cmd(input logic [7:0] m, input bit second);
    logic [7:0] hd [4];
    int b, d1, d2;
    hd[0] = 8'h00; hd[1] = 8'h3F; hd[2] = 8'h7F; hd[3] = 8'hBF;  // N W S E
    b = 0;
    while (b < 7 && m[b] == 1'b0) b++;
    d1 = b / 2;
    if (d1 == 0 || d1 == 2) d2 = (b % 2 == 1) ? 3 : 1;
    else                    d2 = (b % 2 == 1) ? 2 : 0;
    if (second) return {4'h3, hd[d2], 4'h1};
    return {4'h2, hd[d1], 4'h2};
  endfunction

  task automatic clear_inputs();
    bus.tour_go = 0; bus.cmd_UART = 16'h0; bus.cmd_rdy_UART = 0;
    bus.clr_cmd_rdy = 0; bus.send_resp = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1;
  endtask

  task automatic start_tour();
    @(negedge clk); bus.tour_go = 1;
    @(negedge clk); bus.tour_go = 0;
  endtask

  // Entered just after the negedge that follows the edge entering a CMD state.
  task automatic issue_leg(input logic [15:0] exp, input int idx, input bit last, input bit rand_go);
    #1;
    check("leg_rdy", 32'(bus.cmd_rdy), 32'd1);
    check("leg_cmd", 32'(bus.cmd), 32'(exp));
    check("leg_indx", 32'(bus.mv_indx), 32'(idx));
    check("leg_resp", 32'(bus.resp), 32'h5A);
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk); #1;
      check("leg_hold", 32'(bus.cmd), 32'(exp));
    end
    @(negedge clk);
    bus.clr_cmd_rdy = 1;
    bus.send_resp = 1'($urandom_range(0, 1));
    @(negedge clk);
    bus.clr_cmd_rdy = 0; bus.send_resp = 0;
    #1;
    check("wait_rdy", 32'(bus.cmd_rdy), 32'd0);
    check("wait_resp", 32'(bus.resp), last ? 32'hA5 : 32'h5A);
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      if (rand_go) bus.tour_go = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    bus.tour_go = 0; bus.send_resp = 1;
    @(negedge clk);
    bus.send_resp = 0;
  endtask

  task automatic run_tour(output int legs);
    legs = 0;
    for (int idx = 0; idx < 24; idx++) begin
      if (mv_tab[idx] == 8'h00) begin
        #1 check("end_rdy", 32'(bus.cmd_rdy), 32'd0);
        @(negedge clk); #1;
        check("end_resp", 32'(bus.resp), 32'hA5);
        check("end_indx", 32'(bus.mv_indx), 32'(idx));
        return;
      end
      issue_leg(leg_cmd(mv_tab[idx], 1'b0), idx, 1'b0, 1'b1);
      issue_leg(leg_cmd(mv_tab[idx], 1'b1), idx, idx == 23, 1'b1);
      legs += 2;
    end
    #1;
    check("done_resp", 32'(bus.resp), 32'hA5);
    check("done_indx", 32'(bus.mv_indx), 32'd23);
    check("done_rdy", 32'(bus.cmd_rdy), 32'd0);
  endtask

  typedef struct {
    logic [15:0] cmd_uart;
    logic        rdy_uart;
    logic        clr;
    logic [15:0] exp_cmd;
    logic        exp_rdy;
    logic        exp_clr_uart;
  } idle_vec_t;

  initial begin
    idle_vec_t vecs [5];
    int legs;

    clear_inputs();
    for (int i = 0; i < 24; i++) mv_tab[i] = 8'h01;
    rst_n = 0;
    bus.cmd_rdy_UART = 1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_indx", 32'(bus.mv_indx), 32'd0);
    check("rst_resp", 32'(bus.resp), 32'hA5);
    check("rst_rdy", 32'(bus.cmd_rdy), 32'd1);
    rst_n = 1;
    bus.cmd_rdy_UART = 0;

    vecs[0] = '{16'h2001, 1'b1, 1'b0, 16'h2001, 1'b1, 1'b0};
    vecs[1] = '{16'h2001, 1'b1, 1'b1, 16'h2001, 1'b1, 1'b1};
    vecs[2] = '{16'hF000, 1'b0, 1'b0, 16'hF000, 1'b0, 1'b0};
    vecs[3] = '{16'h1234, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b1};
    vecs[4] = '{16'h37F1, 1'b1, 1'b0, 16'h37F1, 1'b1, 1'b0};
    foreach (vecs[i]) begin
      @(negedge clk);
      bus.cmd_UART = vecs[i].cmd_uart;
      bus.cmd_rdy_UART = vecs[i].rdy_uart;
      bus.clr_cmd_rdy = vecs[i].clr;
      #1;
      check("idle_cmd", 32'(bus.cmd), 32'(vecs[i].exp_cmd));
      check("idle_rdy", 32'(bus.cmd_rdy), 32'(vecs[i].exp_rdy));
      check("idle_clr", 32'(bus.clr_cmd_rdy_UART), 32'(vecs[i].exp_clr_uart));
      check("idle_resp", 32'(bus.resp), 32'hA5);
    end
    clear_inputs();

    // Directed tour: one-hot walk with E/S at index 5.
    for (int i = 0; i < 24; i++) mv_tab[i] = 8'(1 << (i % 8));
    mv_tab[5] = 8'h80;
    start_tour();
    run_tour(legs);
    check("legs_full", 32'(legs), 32'd48);

    // Random multi-bit tours; each restart must begin from index 0.
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 24; i++) mv_tab[i] = 8'($urandom_range(1, 255));
      start_tour();
      run_tour(legs);
      check("legs_rand", 32'(legs), 32'd48);
    end

    // Zero move mid-tour ends it.
    for (int i = 0; i < 24; i++) mv_tab[i] = 8'($urandom_range(1, 255));
    mv_tab[3] = 8'h00;
    start_tour();
    run_tour(legs);
    check("legs_short", 32'(legs), 32'd6);

    // Reset while in L2_WAIT at index 2.
    for (int i = 0; i < 24; i++) mv_tab[i] = 8'h20;
    start_tour();
    for (int idx = 0; idx < 2; idx++) begin
      issue_leg(leg_cmd(8'h20, 1'b0), idx, 1'b0, 1'b0);
      issue_leg(leg_cmd(8'h20, 1'b1), idx, 1'b0, 1'b0);
    end
    issue_leg(leg_cmd(8'h20, 1'b0), 2, 1'b0, 1'b0);
    #1 check("l2_rdy", 32'(bus.cmd_rdy), 32'd1);
    @(negedge clk); bus.clr_cmd_rdy = 1;
    @(negedge clk); bus.clr_cmd_rdy = 0; rst_n = 0;
    @(negedge clk); rst_n = 1;
    #1;
    check("mrst_indx", 32'(bus.mv_indx), 32'd0);
    check("mrst_resp", 32'(bus.resp), 32'hA5);
    repeat (3) @(negedge clk);
    #1 check("mrst_rdy", 32'(bus.cmd_rdy), 32'd0);

    // UART abort command during L1_WAIT.
    for (int i = 0; i < 24; i++) mv_tab[i] = 8'h04;
    start_tour();
    #1 check("ab_rdy", 32'(bus.cmd_rdy), 32'd1);
    @(negedge clk); bus.clr_cmd_rdy = 1;
    @(negedge clk); bus.clr_cmd_rdy = 0;
    bus.cmd_UART = 16'hF000; bus.cmd_rdy_UART = 1;
    #1;
`ifdef TOUR_ABORT_EN
    check("ab_pulse", 32'(bus.clr_cmd_rdy_UART), 32'd1);
`else
    check("ab_pulse", 32'(bus.clr_cmd_rdy_UART), 32'd0);
`endif
    check("ab_nopass", 32'(bus.cmd_rdy), 32'd0);
    @(negedge clk); #1;
    check("ab_once", 32'(bus.clr_cmd_rdy_UART), 32'd0);
    bus.cmd_rdy_UART = 0;
    @(negedge clk); bus.send_resp = 1;
    @(negedge clk); bus.send_resp = 0;
    #1;
`ifdef TOUR_ABORT_EN
    check("ab_resp", 32'(bus.resp), 32'hA5);
    check("ab_indx", 32'(bus.mv_indx), 32'd0);
    check("ab_rdy2", 32'(bus.cmd_rdy), 32'd0);
`else
    check("ab_resp", 32'(bus.resp), 32'h5A);
    check("ab_rdy2", 32'(bus.cmd_rdy), 32'd1);
    check("ab_cmd2", 32'(bus.cmd), 32'(leg_cmd(8'h04, 1'b1)));
`endif
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
